// File: rtl/csa_result_checker.sv
// On-chip scoreboard for the carry-save adder pipeline: realigns A/B with the adder's sum,
// checks (A+B) mod 2^N, counts passes/failures and captures the first failing transaction.
module csa_result_checker #(
  parameter int N       = 32,
  parameter int LATENCY = 4,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          stop_on_err,
  input  logic          valid_in,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [N-1:0]  sum,
  output logic          mismatch,
  output logic          error_sticky,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] err_count,
  output logic [N-1:0]  first_a,
  output logic [N-1:0]  first_b,
  output logic [N-1:0]  first_sum,
  output logic [1:0]    state
);

  localparam int FW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [FW-1:0] FILL_LOAD = FW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    CHECK = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [FW-1:0]             fill_cnt_r;
  logic [LATENCY-1:0]        dly_v_r;
  logic [LATENCY-1:0][N-1:0] dly_a_r;
  logic [LATENCY-1:0][N-1:0] dly_b_r;
  logic [N-1:0]              exp_s;
  logic                      cmp_s;
  logic                      fail_s;
  logic                      mismatch_r;
  logic                      error_sticky_r;
  logic [CW-1:0]             pass_count_r;
  logic [CW-1:0]             err_count_r;
  logic [N-1:0]              first_a_r;
  logic [N-1:0]              first_b_r;
  logic [N-1:0]              first_sum_r;

  // Carry out of the top bit is intentionally discarded.
  function automatic logic [N-1:0] expected_sum(input logic [N-1:0] a, input logic [N-1:0] b);
    return a + b;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CW'(1'b1);
    end
  endfunction

  assign exp_s  = expected_sum(dly_a_r[LATENCY-1], dly_b_r[LATENCY-1]);
  assign cmp_s  = (state_r == CHECK) && dly_v_r[LATENCY-1];
  assign fail_s = cmp_s && (exp_s != sum);

  // Operand delay line; the last stage lines up with the adder's current sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_v_r <= '0;
      dly_a_r <= '0;
      dly_b_r <= '0;
    end else if (state_r != HALT) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        dly_v_r[i] <= dly_v_r[i-1];
        dly_a_r[i] <= dly_a_r[i-1];
        dly_b_r[i] <= dly_b_r[i-1];
      end
      dly_v_r[0] <= valid_in;
      dly_a_r[0] <= A;
      dly_b_r[0] <= B;
    end
  end

  // Fill counter: preloaded while idle, counts down while the delay line primes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      fill_cnt_r <= FILL_LOAD;
    end else if ((state_r == FILL) && (fill_cnt_r != '0)) begin
      fill_cnt_r <= fill_cnt_r - FW'(1'b1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; dropping enable always wins and returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (fill_cnt_r == '0) begin
          state_s = CHECK;
        end else begin
          state_s = FILL;
        end
      end
      CHECK: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (fail_s && stop_on_err) begin
          state_s = HALT;
        end else begin
          state_s = CHECK;
        end
      end
      HALT: begin
        if (!enable) begin
          state_s = IDLE;
        end else begin
          state_s = HALT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Scoreboard: counters, mismatch pulse and first-failure capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_r     <= 1'b0;
      error_sticky_r <= 1'b0;
      pass_count_r   <= '0;
      err_count_r    <= '0;
      first_a_r      <= '0;
      first_b_r      <= '0;
      first_sum_r    <= '0;
    end else begin
      mismatch_r <= fail_s;
      if (fail_s) begin
        err_count_r <= sat_inc(err_count_r);
        if (!error_sticky_r) begin
          error_sticky_r <= 1'b1;
          first_a_r      <= dly_a_r[LATENCY-1];
          first_b_r      <= dly_b_r[LATENCY-1];
          first_sum_r    <= sum;
        end
      end else if (cmp_s) begin
        pass_count_r <= sat_inc(pass_count_r);
      end
    end
  end

  assign mismatch     = mismatch_r;
  assign error_sticky = error_sticky_r;
  assign pass_count   = pass_count_r;
  assign err_count    = err_count_r;
  assign first_a      = first_a_r;
  assign first_b      = first_b_r;
  assign first_sum    = first_sum_r;
  assign state        = state_r;

endmodule

// File: tb/tb_csa_result_checker.sv
// Randomized self-checking bench for csa_result_checker: a behavioural adder drives sum,
// and a transaction-level scoreboard predicts counts, pulses and the first-failure capture.
module tb_csa_result_checker;

  localparam int L = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        stop_on_err;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        fault;

  logic        mismatch;
  logic        error_sticky;
  logic [15:0] pass_count;
  logic [15:0] err_count;
  logic [31:0] first_a;
  logic [31:0] first_b;
  logic [31:0] first_sum;
  logic [1:0]  state;

  logic        mismatch4;
  logic        error_sticky4;
  logic [3:0]  pass_count4;
  logic [3:0]  err_count4;
  logic [31:0] first_a4;
  logic [31:0] first_b4;
  logic [31:0] first_sum4;
  logic [1:0]  state4;

  int checks = 0;
  int errors = 0;

  csa_result_checker #(.N(32), .LATENCY(L), .CW(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .stop_on_err(stop_on_err),
    .valid_in(valid_in), .A(a), .B(b), .sum(sum),
    .mismatch(mismatch), .error_sticky(error_sticky),
    .pass_count(pass_count), .err_count(err_count),
    .first_a(first_a), .first_b(first_b), .first_sum(first_sum), .state(state)
  );

  csa_result_checker #(.N(32), .LATENCY(L), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .stop_on_err(stop_on_err),
    .valid_in(valid_in), .A(a), .B(b), .sum(sum),
    .mismatch(mismatch4), .error_sticky(error_sticky4),
    .pass_count(pass_count4), .err_count(err_count4),
    .first_a(first_a4), .first_b(first_b4), .first_sum(first_sum4), .state(state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder: L-cycle pipelined A+B, with an optional bit-0 fault injected.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (a + b) ^ {31'd0, fault};
  end
  assign sum = pipe[L-1];

  // Transaction list for the next stream and the scoreboard's running state.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          qv[$];
  bit          qf[$];
  int          m_pass, m_err, dut_pulses;
  bit          m_halt, m_sticky;
  logic [31:0] m_fa, m_fb, m_fs;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_txn(input bit v, input logic [31:0] x, input logic [31:0] y, input bit f);
    qv.push_back(v);
    qa.push_back(x);
    qb.push_back(y);
    qf.push_back(f);
  endtask

  task automatic model_clear();
    m_pass = 0; m_err = 0; dut_pulses = 0;
    m_halt = 1'b0; m_sticky = 1'b0;
    m_fa = 32'd0; m_fb = 32'd0; m_fs = 32'd0;
  endtask

  // Reset with live traffic on the inputs, then watch the FILL -> CHECK bring-up.
  task automatic do_reset(input bit vld);
    reset = 1'b0; enable = 1'b1; valid_in = vld; fault = vld;
    a = $urandom; b = $urandom;
    repeat (3) cycle();
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_pass", pass_count, 16'd0);
    check_eq("rst_err", err_count, 16'd0);
    check_eq("rst_sticky", error_sticky, 1'b0);
    check_eq("rst_mismatch", mismatch, 1'b0);
    check_eq("rst_first_sum", first_sum, 32'd0);
    reset = 1'b1; valid_in = 1'b0; fault = 1'b0;
    model_clear();
    for (int i = 0; i < L; i++) begin
      cycle();
      check_eq("fill_state", state, 2'b01);
    end
    cycle();
    check_eq("check_state", state, 2'b10);
  endtask

  // Play the queued transactions and score each compare when its mismatch pulse is due.
  task automatic stream();
    int  len;
    int  j;
    bit  exp_mm;
    len = qa.size();
    for (int k = 0; k < len + L + 2; k++) begin
      if (k < len) begin
        valid_in = qv[k]; a = qa[k]; b = qb[k]; fault = qf[k];
      end else begin
        valid_in = 1'b0; fault = 1'b0;
      end
      cycle();
      j = k - L;
      exp_mm = 1'b0;
      if (j >= 0 && j < len && !m_halt && qv[j]) begin
        if (qf[j]) begin
          m_err++;
          exp_mm = 1'b1;
          if (!m_sticky) begin
            m_sticky = 1'b1;
            m_fa = qa[j]; m_fb = qb[j]; m_fs = (qa[j] + qb[j]) ^ 32'd1;
          end
          if (stop_on_err) m_halt = 1'b1;
        end else begin
          m_pass++;
        end
      end
      if (mismatch) dut_pulses++;
      check_eq("mismatch_pulse", mismatch, exp_mm);
    end
    qa.delete(); qb.delete(); qv.delete(); qf.delete();
  endtask

  task automatic final_checks();
    check_eq("pass_count", pass_count, (m_pass > 65535) ? 65535 : m_pass);
    check_eq("err_count", err_count, (m_err > 65535) ? 65535 : m_err);
    check_eq("pass_count_cw4", pass_count4, (m_pass > 15) ? 15 : m_pass);
    check_eq("err_count_cw4", err_count4, (m_err > 15) ? 15 : m_err);
    check_eq("error_sticky", error_sticky, m_sticky);
    check_eq("first_a", first_a, m_fa);
    check_eq("first_b", first_b, m_fb);
    check_eq("first_sum", first_sum, m_fs);
    check_eq("pulse_total", dut_pulses, m_err);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; stop_on_err = 1'b0; valid_in = 1'b0;
    a = 32'd0; b = 32'd0; fault = 1'b0;
    model_clear();
    @(negedge clk);

    // Reset held with enable and valid high, then the ramp on a correct adder.
    do_reset(1'b1);
    for (int i = 0; i < 100; i++) push_txn(1'b1, i, 2 * i, 1'b0);
    stream();
    final_checks();
    check_eq("ramp_pass", pass_count, 16'd100);
    check_eq("ramp_err", err_count, 16'd0);

    // Wrap-around: carry out is dropped.
    do_reset(1'b0);
    push_txn(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    stream();
    final_checks();
    check_eq("wrap_pass", pass_count, 16'd1);

    // Single fault on transaction 10, keep running.
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) push_txn(1'b1, i, 2 * i, i == 10);
    stream();
    final_checks();
    check_eq("fault_err", err_count, 16'd1);
    check_eq("fault_pass", pass_count, 16'd99);
    check_eq("fault_first_a", first_a, 32'd10);
    check_eq("fault_first_b", first_b, 32'd20);
    check_eq("fault_first_sum", first_sum, 32'd31);

    // Same fault with stop_on_err: freeze in HALT, then enable=0 back to IDLE.
    do_reset(1'b0);
    stop_on_err = 1'b1;
    for (int i = 0; i < 100; i++) push_txn(1'b1, i, 2 * i, i == 10);
    stream();
    final_checks();
    check_eq("halt_state", state, 2'b11);
    check_eq("halt_pass", pass_count, 16'd10);
    check_eq("halt_err", err_count, 16'd1);
    enable = 1'b0;
    cycle();
    check_eq("halt_exit_state", state, 2'b00);
    check_eq("halt_exit_pass", pass_count, 16'd10);
    check_eq("halt_exit_err", err_count, 16'd1);
    stop_on_err = 1'b0;

    // Saturation with gaps: CW=4 instance must stop at 15.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      push_txn(1'b1, $urandom, $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) push_txn(1'b0, $urandom, $urandom, 1'b1);
    end
    stream();
    final_checks();
    check_eq("sat_pass_cw4", pass_count4, 4'd15);
    check_eq("sat_pass", pass_count, 16'd20);

    // Random traffic with sparse faults.
    do_reset(1'b0);
    for (int i = 0; i < 300; i++)
      push_txn($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 7) == 0);
    stream();
    final_checks();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
